// File: rtl/fadd_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor (round-toward-zero, flush-to-zero).
// One operation walks IDLE->UNPK->ALIGN->ADD->NORM->PACK; result and flags are registered in PACK.
module fadd_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter logic [31:0] MAXF = 32'h7F7F_FFFF
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        invalid
);

  typedef enum logic [2:0] {S_IDLE, S_UNPK, S_ALIGN, S_ADD, S_NORM, S_PACK} state_t;

  state_t state_q, state_d;

  logic [31:0] op_a_q, op_b_q;
  logic        sa_q, sb_q, inv_q, inf_q, inf_s_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] ma_q, mb_q;
  logic        sx_q, sy_q;
  logic [7:0]  ex_q;
  logic [23:0] mx_q, my_q;
  logic [24:0] sum_q;
  logic [23:0] mn_q;
  logic signed [9:0] en_q;
  logic        zn_q;
  logic        busy_q, done_q, zero_q, ovf_q, invo_q;
  logic [31:0] result_q;

  // Leading-zero count of a 24-bit mantissa; 24 for an all-zero input.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_UNPK;
      S_UNPK:  state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_PACK;
      S_PACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Unpack
  logic [7:0]  a_exp, b_exp;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [23:0] ma_d, mb_d;
  assign a_exp = op_a_q[30:23];
  assign b_exp = op_b_q[30:23];
  assign a_nan = (a_exp == 8'hFF) && (op_a_q[22:0] != 23'd0);
  assign b_nan = (b_exp == 8'hFF) && (op_b_q[22:0] != 23'd0);
  assign a_inf = (a_exp == 8'hFF) && (op_a_q[22:0] == 23'd0);
  assign b_inf = (b_exp == 8'hFF) && (op_b_q[22:0] == 23'd0);
  assign ma_d  = (a_exp == 8'd0) ? 24'd0 : {1'b1, op_a_q[22:0]};
  assign mb_d  = (b_exp == 8'd0) ? 24'd0 : {1'b1, op_b_q[22:0]};

  // Align: X is the larger magnitude, Y is shifted right with truncation
  logic        a_ge;
  logic [7:0]  e_big, e_small, e_diff;
  logic [23:0] m_small, m_shift;
  assign a_ge    = {ea_q, ma_q} >= {eb_q, mb_q};
  assign e_big   = a_ge ? ea_q : eb_q;
  assign e_small = a_ge ? eb_q : ea_q;
  assign m_small = a_ge ? mb_q : ma_q;
  assign e_diff  = e_big - e_small;
  assign m_shift = (e_diff >= 8'd25) ? 24'd0 : (m_small >> e_diff);

  // Normalize
  logic [4:0]        lz;
  logic signed [9:0] e_ext, en_d;
  logic [23:0]       mn_d;
  assign lz    = lzc24(sum_q[23:0]);
  assign e_ext = $signed({2'b00, ex_q});
  assign en_d  = sum_q[24] ? e_ext + 10'sd1 : e_ext - $signed({5'b00000, lz});
  assign mn_d  = sum_q[24] ? sum_q[24:1] : (sum_q[23:0] << lz);

  // Pack: specials take priority over the arithmetic path
  logic [31:0] res_pk;
  logic        z_pk, o_pk, i_pk;
  always_comb begin
    res_pk = {sx_q, en_q[7:0], mn_q[22:0]};
    z_pk   = 1'b0;
    o_pk   = 1'b0;
    i_pk   = 1'b0;
    if (inv_q) begin
      res_pk = QNAN;
      i_pk   = 1'b1;
    end else if (inf_q) begin
      res_pk = {inf_s_q, 8'hFF, 23'd0};
    end else if (zn_q) begin
      res_pk = 32'h0000_0000;
      z_pk   = 1'b1;
    end else if (en_q <= 10'sd0) begin
      res_pk = {sx_q, 31'd0};
      z_pk   = 1'b1;
    end else if (en_q >= 10'sd255) begin
      res_pk = {sx_q, MAXF[30:0]};
      o_pk   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      op_a_q <= '0; op_b_q <= '0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      inv_q <= 1'b0; inf_q <= 1'b0; inf_s_q <= 1'b0;
      sx_q <= 1'b0; sy_q <= 1'b0; ex_q <= '0; mx_q <= '0; my_q <= '0;
      sum_q <= '0; mn_q <= '0; en_q <= '0; zn_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; result_q <= '0;
      zero_q <= 1'b0; ovf_q <= 1'b0; invo_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          op_a_q <= a;
          op_b_q <= b ^ {sub, 31'd0};
          busy_q <= 1'b1;
        end
        S_UNPK: begin
          sa_q    <= op_a_q[31];
          sb_q    <= op_b_q[31];
          ea_q    <= a_exp;
          eb_q    <= b_exp;
          ma_q    <= ma_d;
          mb_q    <= mb_d;
          inv_q   <= a_nan | b_nan | (a_inf & b_inf & (op_a_q[31] != op_b_q[31]));
          inf_q   <= a_inf | b_inf;
          inf_s_q <= a_inf ? op_a_q[31] : op_b_q[31];
        end
        S_ALIGN: begin
          sx_q <= a_ge ? sa_q : sb_q;
          sy_q <= a_ge ? sb_q : sa_q;
          ex_q <= e_big;
          mx_q <= a_ge ? ma_q : mb_q;
          my_q <= m_shift;
        end
        S_ADD: sum_q <= (sx_q == sy_q) ? ({1'b0, mx_q} + {1'b0, my_q})
                                       : ({1'b0, mx_q} - {1'b0, my_q});
        S_NORM: begin
          mn_q <= mn_d;
          en_q <= en_d;
          zn_q <= (sum_q == 25'd0);
        end
        S_PACK: begin
          result_q <= res_pk;
          zero_q   <= z_pk;
          ovf_q    <= o_pk;
          invo_q   <= i_pk;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign invalid  = invo_q;

endmodule

// File: tb/tb_fadd_seq.sv
// Self-checking bench for fadd_seq: directed table, control-path sequences and random ops
// checked against an arithmetic reference model.
module tb_fadd_seq;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        RSTN, start, sub;
  logic [31:0] a, b;
  logic        busy, done, zero, overflow, invalid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  fadd_seq dut (
    .clk(clk), .RSTN(RSTN), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .zero(zero), .overflow(overflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] res;
    logic        z, o, i;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference: value = mant * 2^(exp-150); align by truncating the smaller operand, add, renormalize.
  function automatic logic [34:0] ref_model(input logic [31:0] a_v, input logic [31:0] b_v,
                                            input logic s_v);
    logic [31:0] bb;
    int     ea, eb, ex, ey, d, e;
    longint ma, mb, mx, my, m;
    logic   sa, sb, sx, sy, nan_a, nan_b, inf_a, inf_b;
    bb = b_v ^ {s_v, 31'd0};
    sa = a_v[31]; sb = bb[31];
    ea = int'(a_v[30:23]); eb = int'(bb[30:23]);
    nan_a = (ea == 255) && (a_v[22:0] != 0);
    nan_b = (eb == 255) && (bb[22:0] != 0);
    inf_a = (ea == 255) && (a_v[22:0] == 0);
    inf_b = (eb == 255) && (bb[22:0] == 0);
    if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) return {QNAN, 3'b001};
    if (inf_a) return {sa, 8'hFF, 23'd0, 3'b000};
    if (inf_b) return {sb, 8'hFF, 23'd0, 3'b000};
    ma = (ea == 0) ? 0 : (longint'(a_v[22:0]) + 8388608);
    mb = (eb == 0) ? 0 : (longint'(bb[22:0]) + 8388608);
    if (longint'(ea) * 16777216 + ma >= longint'(eb) * 16777216 + mb) begin
      sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
    end else begin
      sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
    end
    d  = ex - ey;
    my = (d >= 25) ? 0 : (my >> d);
    m  = (sx == sy) ? mx + my : mx - my;
    if (m == 0) return {32'h0, 3'b100};
    e = ex;
    while (m >= 16777216) begin m = m >> 1; e++; end
    while (m < 8388608)   begin m = m << 1; e--; end
    if (e <= 0)   return {sx, 31'd0, 3'b100};
    if (e >= 255) return {sx, 31'h7F7F_FFFF, 3'b010};
    return {sx, 8'(e), m[22:0], 3'b000};
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge following done.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        output logic [31:0] r, output logic z, output logic o, output logic iv);
    int lat;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    check("latency", lat, 5);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    r = result; z = zero; o = overflow; iv = invalid;
    $display("op a=%h b=%h sub=%0d -> result=%h z=%0d o=%0d i=%0d lat=%0d",
             ta, tb_v, ts, r, z, o, iv, lat);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic check_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] er, input logic ez,
                          input logic eo, input logic ei);
    logic [31:0] r;
    logic z, o, iv;
    run_op(ta, tb_v, ts, r, z, o, iv);
    check({tag, "_result"}, r, er);
    check({tag, "_zero"}, {31'd0, z}, {31'd0, ez});
    check({tag, "_ovf"}, {31'd0, o}, {31'd0, eo});
    check({tag, "_inv"}, {31'd0, iv}, {31'd0, ei});
  endtask

  initial begin
    logic [34:0] exp_v;
    logic [31:0] ra, rb;
    logic        rs;
    int          ndone;
    logic [31:0] seen;

    vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h4120_0000, 32'h4040_0000, 1'b1, 32'h40E0_0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h3F80_0000, 32'h3F80_0001, 1'b1, 32'hB400_0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF7F_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h7FC0_1234, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0};

    RSTN = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_inv", {31'd0, invalid}, 32'd0);
    RSTN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
               vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].i);

    // Second start while busy must be ignored.
    a = 32'h3F80_0000; b = 32'h4000_0000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 32'h7F80_0000; b = 32'hFF80_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; seen = '0;
    for (int n = 0; n < 15; n++) begin
      if (done) begin ndone++; seen = result; end
      @(posedge clk); #1;
    end
    check("ignored_start_dones", ndone, 1);
    check("ignored_start_result", seen, 32'h4040_0000);
    $display("op ignored-start sequence: dones=%0d result=%h", ndone, seen);

    // Reset while in ALIGN discards the operation.
    a = 32'h4120_0000; b = 32'h4040_0000; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    RSTN = 1'b0;
    @(posedge clk); #1;
    RSTN = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    $display("op mid-operation reset: dones after reset=%0d", ndone);
    check_op("after_rst", 32'h4120_0000, 32'h4040_0000, 1'b1, 32'h40E0_0000, 1'b0, 1'b0, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      int k;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      k = $urandom_range(0, 15);
      if (k < 8) rb[30:23] = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
      if (k == 8)  ra[30:23] = 8'hFF;
      if (k == 9)  rb[30:23] = 8'hFF;
      if (k == 10) ra[30:23] = 8'h00;
      if (k == 11) rb = ra;
      if (k == 12) begin ra[30:23] = 8'd254; rb[30:23] = 8'd254; end
      if (k == 13) begin ra[30:23] = 8'd2; rb[30:23] = 8'd1; end
      exp_v = ref_model(ra, rb, rs);
      check_op($sformatf("rnd%0d", i), ra, rb, rs, exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
